// File: rtl/recovery_release_seq_if.sv
// Bundles the request/status lines between reset sources, the sequencer and the
// downstream flop bank it guards.
interface recovery_release_seq_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0] req;
  logic             async_out;
  logic             clk_en;
  logic             ready;
  logic [N_REQ-1:0] src_latched;
  logic [7:0]       abort_count;
  logic [1:0]       state_o;

  modport master (
    output req,
    input  async_out, clk_en, ready, src_latched, abort_count, state_o
  );

  modport slave (
    input  req,
    output async_out, clk_en, ready, src_latched, abort_count, state_o
  );
endinterface

// File: rtl/recovery_release_seq.sv
// Holds an async control line high for a minimum width, releases it on a clock
// edge and keeps the downstream clock enable low for a full recovery window.
module recovery_release_seq #(
  parameter int N_REQ        = 2,
  parameter int ASSERT_CYC   = 4,
  parameter int RECOVERY_CYC = 5
) (
  input logic                   clk,
  input logic                   rst,
  recovery_release_seq_if.slave bus
);

  localparam int CNT_MAX = (ASSERT_CYC > RECOVERY_CYC) ? ASSERT_CYC : RECOVERY_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    RECOVER = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             asyncOut_q;
  logic             clkEn_q;
  logic             ready_q;
  logic [N_REQ-1:0] srcLatched_q;
  logic [7:0]       abortCount_q;
  logic             reqAny;

  assign reqAny = |bus.req;

  // A request always wins over recovery completion, so clk_en can only rise
  // after an uninterrupted RECOVERY_CYC cycles with async_out low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HOLD;
      cnt_q        <= '0;
      asyncOut_q   <= 1'b1;
      clkEn_q      <= 1'b0;
      ready_q      <= 1'b0;
      srcLatched_q <= '0;
      abortCount_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (reqAny) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            asyncOut_q   <= 1'b1;
            clkEn_q      <= 1'b0;
            ready_q      <= 1'b0;
            srcLatched_q <= bus.req;
          end
        end
        HOLD: begin
          srcLatched_q <= srcLatched_q | bus.req;
          if (cnt_q < CNT_W'(ASSERT_CYC - 1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else if (!reqAny) begin
            state_q    <= RECOVER;
            cnt_q      <= '0;
            asyncOut_q <= 1'b0;
          end
        end
        RECOVER: begin
          if (reqAny) begin
            state_q      <= HOLD;
            cnt_q        <= '0;
            asyncOut_q   <= 1'b1;
            srcLatched_q <= srcLatched_q | bus.req;
            if (abortCount_q != 8'hFF) begin
              abortCount_q <= abortCount_q + 8'd1;
            end
          end else if (cnt_q == CNT_W'(RECOVERY_CYC - 1)) begin
            state_q <= RUN;
            clkEn_q <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= HOLD;
          cnt_q      <= '0;
          asyncOut_q <= 1'b1;
          clkEn_q    <= 1'b0;
          ready_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.async_out   = asyncOut_q;
  assign bus.clk_en      = clkEn_q;
  assign bus.ready       = ready_q;
  assign bus.src_latched = srcLatched_q;
  assign bus.abort_count = abortCount_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_recovery_release_seq.sv
// Directed bench for the recovery/release sequencer: a vector table for the
// reset and single-pulse sequences, then hand-written abort/saturation runs.
module tb_recovery_release_seq;

  logic clk;
  logic rst;

  recovery_release_seq_if #(.N_REQ(2)) bus ();

  recovery_release_seq #(
    .N_REQ(2),
    .ASSERT_CYC(4),
    .RECOVERY_CYC(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic       expAsync;
    logic       expClkEn;
    logic       expReady;
    logic [1:0] expSrc;
    logic [7:0] expAbort;
    logic [1:0] expState;
  } vec_t;

  vec_t vecs [23];
  int   checks;
  int   passes;
  int   lowRun;
  logic prevClkEn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic r, logic [1:0] q, logic a, logic c, logic y,
                                 logic [1:0] s, logic [7:0] ab, logic [1:0] st);
    vec_t v;
    v.rst = r; v.req = q; v.expAsync = a; v.expClkEn = c; v.expReady = y;
    v.expSrc = s; v.expAbort = ab; v.expState = st;
    return v;
  endfunction

  // Every cycle also checks the safety invariants: never async_out and clk_en
  // together, and clk_en only rises after RECOVERY_CYC full low cycles.
  task automatic applyStimulus(input logic rstV, input logic [1:0] reqV);
    rst     = rstV;
    bus.req = reqV;
    @(posedge clk);
    #1;
    checks++;
    if (bus.async_out === 1'b1 && bus.clk_en === 1'b1)
      $display("[TB] FAIL overlap: async_out=%b clk_en=%b, required not both 1", bus.async_out, bus.clk_en);
    else
      passes++;
    if (bus.async_out === 1'b0) lowRun++;
    else lowRun = 0;
    if (bus.clk_en === 1'b1 && prevClkEn !== 1'b1) begin
      checks++;
      if (lowRun < 6)
        $display("[TB] FAIL recovery_window: low cycles before clk_en=%0d, required >= 5", lowRun - 1);
      else
        passes++;
    end
    prevClkEn = bus.clk_en;
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00);
  endtask

  task automatic checkOutput(input string name, input logic a, input logic c, input logic y,
                             input logic [1:0] s, input logic [7:0] ab, input logic [1:0] st);
    logic [14:0] act;
    logic [14:0] exp;
    act = {bus.async_out, bus.clk_en, bus.ready, bus.src_latched, bus.abort_count, bus.state_o};
    exp = {a, c, y, s, ab, st};
    checks++;
    if (act === exp) passes++;
    else
      $display("[TB] FAIL %s: got async=%b clk_en=%b ready=%b src=%b abort=%0d state=%0d, required async=%b clk_en=%b ready=%b src=%b abort=%0d state=%0d",
               name, bus.async_out, bus.clk_en, bus.ready, bus.src_latched, bus.abort_count,
               bus.state_o, a, c, y, s, ab, st);
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    lowRun    = 0;
    prevClkEn = 1'b0;
    rst       = 1'b1;
    bus.req   = 2'b00;

    // Reset then idle release, followed by a single-cycle pulse from RUN.
    vecs[0]  = mkVec(1, 2'b00, 1, 0, 0, 2'b00, 8'd0, 2'd1);
    vecs[1]  = mkVec(1, 2'b00, 1, 0, 0, 2'b00, 8'd0, 2'd1);
    for (int i = 2; i <= 4; i++)   vecs[i] = mkVec(0, 2'b00, 1, 0, 0, 2'b00, 8'd0, 2'd1);
    for (int i = 5; i <= 9; i++)   vecs[i] = mkVec(0, 2'b00, 0, 0, 0, 2'b00, 8'd0, 2'd2);
    for (int i = 10; i <= 11; i++) vecs[i] = mkVec(0, 2'b00, 0, 1, 1, 2'b00, 8'd0, 2'd0);
    vecs[12] = mkVec(0, 2'b01, 1, 0, 0, 2'b01, 8'd0, 2'd1);
    for (int i = 13; i <= 15; i++) vecs[i] = mkVec(0, 2'b00, 1, 0, 0, 2'b01, 8'd0, 2'd1);
    for (int i = 16; i <= 20; i++) vecs[i] = mkVec(0, 2'b00, 0, 0, 0, 2'b01, 8'd0, 2'd2);
    for (int i = 21; i <= 22; i++) vecs[i] = mkVec(0, 2'b00, 0, 1, 1, 2'b01, 8'd0, 2'd0);

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req);
      checkOutput($sformatf("vec%0d", i), vecs[i].expAsync, vecs[i].expClkEn, vecs[i].expReady,
                  vecs[i].expSrc, vecs[i].expAbort, vecs[i].expState);
    end

    // Held request extends the hold until the edge after it drops.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'b10);
    checkOutput("held_hold", 1, 0, 0, 2'b10, 8'd0, 2'd1);
    applyStimulus(1'b0, 2'b00);
    checkOutput("held_release", 0, 0, 0, 2'b10, 8'd0, 2'd2);
    runIdle(4);
    checkOutput("held_recover_end", 0, 0, 0, 2'b10, 8'd0, 2'd2);
    runIdle(1);
    checkOutput("held_run", 0, 1, 1, 2'b10, 8'd0, 2'd0);

    // Abort on the third RECOVER cycle.
    applyStimulus(1'b0, 2'b01);
    runIdle(4);
    checkOutput("abort_recover", 0, 0, 0, 2'b01, 8'd0, 2'd2);
    runIdle(2);
    applyStimulus(1'b0, 2'b10);
    checkOutput("abort_rehold", 1, 0, 0, 2'b11, 8'd1, 2'd1);
    runIdle(3);
    checkOutput("abort_hold_end", 1, 0, 0, 2'b11, 8'd1, 2'd1);
    runIdle(1);
    checkOutput("abort_recover2", 0, 0, 0, 2'b11, 8'd1, 2'd2);
    runIdle(5);
    checkOutput("abort_run", 0, 1, 1, 2'b11, 8'd1, 2'd0);

    // Request on the final RECOVER edge goes back to HOLD, not RUN.
    applyStimulus(1'b0, 2'b01);
    runIdle(4);
    runIdle(4);
    applyStimulus(1'b0, 2'b01);
    checkOutput("priority_hold", 1, 0, 0, 2'b01, 8'd2, 2'd1);
    runIdle(9);
    checkOutput("priority_run", 0, 1, 1, 2'b01, 8'd2, 2'd0);

    // Reset mid-RECOVER clears everything and reruns the full sequence.
    applyStimulus(1'b0, 2'b10);
    runIdle(5);
    applyStimulus(1'b1, 2'b00);
    checkOutput("rst_recover", 1, 0, 0, 2'b00, 8'd0, 2'd1);
    runIdle(3);
    checkOutput("rst_hold_end", 1, 0, 0, 2'b00, 8'd0, 2'd1);
    runIdle(1);
    checkOutput("rst_recover2", 0, 0, 0, 2'b00, 8'd0, 2'd2);
    runIdle(5);
    checkOutput("rst_run", 0, 1, 1, 2'b00, 8'd0, 2'd0);

    // Repeated aborts saturate the counter.
    applyStimulus(1'b0, 2'b01);
    for (int i = 1; i <= 300; i++) begin
      runIdle(4);
      applyStimulus(1'b0, 2'b10);
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
        checkOutput($sformatf("sat_%0d", i), 1, 0, 0, 2'b11, (i > 255) ? 8'd255 : 8'(i), 2'd1);
    end
    runIdle(9);
    checkOutput("sat_run", 0, 1, 1, 2'b11, 8'd255, 2'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
